// File: rtl/mod3_pkg.sv
// Shared definitions for the mod-3 datapath: FSM state encoding and the
// remainder type/constants used by both the counter stage and the stream checker.
package mod3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01
   } state_t;

   typedef logic [1:0] rem_t;

   localparam rem_t S0 = 2'd0;
   localparam rem_t S1 = 2'd1;
   localparam rem_t S2 = 2'd2;

endpackage

// File: rtl/mod3_step.sv
// One MSB-first step of the running remainder: rem_next = (2*rem + bit_in) mod 3.
module mod3_step
   import mod3_pkg::*;
(
   input  logic [1:0] rem,
   input  logic       bit_in,
   output logic [1:0] rem_next
);

   // Remainder transition table; the unused code 3 is congruent to 0
   always_comb begin
      rem_next = S0;
      case (rem)
         S0:      rem_next = bit_in ? S1 : S0;
         S1:      rem_next = bit_in ? S0 : S2;
         S2:      rem_next = bit_in ? S2 : S1;
         default: rem_next = bit_in ? S1 : S0;
      endcase
   end

endmodule

// File: rtl/mod3_stream_checker.sv
// Framed serial divisibility-by-three checker: per-frame remainder, length and
// divisibility result, plus a saturating count of divisible frames.
module mod3_stream_checker
   import mod3_pkg::*;
#(
   parameter int LEN_W = 6,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             sof,
   input  logic             eof,
   output logic             res_valid,
   output logic             res_div3,
   output logic [1:0]       res_rem,
   output logic [LEN_W-1:0] res_len,
   output logic [CNT_W-1:0] div_count,
   output logic             err
);

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r, state_nxt_s;
   rem_t             rem_r, rem_nxt_s, step_rem_s;
   logic [LEN_W-1:0] len_r, len_nxt_s, len_inc_s;
   logic             emit_s, err_s;

   logic             res_valid_r, res_div3_r, err_r;
   rem_t             res_rem_r;
   logic [LEN_W-1:0] res_len_r;
   logic [CNT_W-1:0] div_count_r;

   mod3_step u_step (
      .rem      (rem_r),
      .bit_in   (bit_in),
      .rem_next (step_rem_s)
   );

   assign len_inc_s = (len_r == LEN_MAX) ? len_r : (len_r + LEN_ONE);

   // Next-state, remainder/length update, result and error strobes
   always_comb begin
      state_nxt_s = state_r;
      rem_nxt_s   = rem_r;
      len_nxt_s   = len_r;
      emit_s      = 1'b0;
      err_s       = 1'b0;
      if (bit_valid) begin
         if (sof) begin
            // A sof inside an open frame aborts it; the bit always starts a new frame
            err_s     = (state_r == RUN);
            rem_nxt_s = bit_in ? S1 : S0;
            len_nxt_s = LEN_ONE;
            if (eof) begin
               emit_s      = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RUN;
            end
         end else begin
            case (state_r)
               RUN: begin
                  rem_nxt_s = step_rem_s;
                  len_nxt_s = len_inc_s;
                  if (eof) begin
                     emit_s      = 1'b1;
                     state_nxt_s = IDLE;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end
               default: begin
                  err_s       = 1'b1;
                  state_nxt_s = IDLE;
               end
            endcase
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Frame state, running remainder and length registers
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_r <= IDLE;
         rem_r   <= S0;
         len_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         rem_r   <= rem_nxt_s;
         len_r   <= len_nxt_s;
      end
   end

   // Result capture, strobes and saturating divisible-frame counter
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         res_valid_r <= 1'b0;
         res_div3_r  <= 1'b0;
         res_rem_r   <= S0;
         res_len_r   <= '0;
         div_count_r <= '0;
         err_r       <= 1'b0;
      end else begin
         res_valid_r <= emit_s;
         err_r       <= err_s;
         if (emit_s) begin
            res_rem_r  <= rem_nxt_s;
            res_div3_r <= (rem_nxt_s == S0);
            res_len_r  <= len_nxt_s;
            if ((rem_nxt_s == S0) && (div_count_r != CNT_MAX)) begin
               div_count_r <= div_count_r + CNT_ONE;
            end
         end
      end
   end

   assign res_valid = res_valid_r;
   assign res_div3  = res_div3_r;
   assign res_rem   = res_rem_r;
   assign res_len   = res_len_r;
   assign div_count = div_count_r;
   assign err       = err_r;

endmodule

// File: tb/tb_mod3_stream_checker.sv
// Self-checking bench: default-width and narrow (LEN_W=3, CNT_W=2) instances
// share one stimulus stream and are checked against a frame-value reference model.
module tb_mod3_stream_checker;

   logic       clk = 1'b0;
   logic       RESET = 1'b1;
   logic       bit_valid = 1'b0, bit_in = 1'b0, sof = 1'b0, eof = 1'b0;

   logic       a_res_valid, a_res_div3, a_err;
   logic [1:0] a_res_rem;
   logic [5:0] a_res_len;
   logic [7:0] a_div_count;
   logic       b_res_valid, b_res_div3, b_err;
   logic [1:0] b_res_rem;
   logic [2:0] b_res_len;
   logic [1:0] b_div_count;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: whole frame value as an integer
   logic            m_open = 1'b0;
   longint unsigned m_val  = 0;
   int              m_len  = 0;
   int              n_div  = 0;
   logic       exp_valid = 1'b0, exp_err = 1'b0, exp_div = 1'b0;
   logic [1:0] exp_rem = 2'd0;
   logic [5:0] exp_len_a = 6'd0;
   logic [2:0] exp_len_b = 3'd0;
   logic [7:0] exp_cnt_a = 8'd0;
   logic [1:0] exp_cnt_b = 2'd0;

   mod3_stream_checker u_a (
      .clk(clk), .RESET(RESET), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof), .eof(eof),
      .res_valid(a_res_valid), .res_div3(a_res_div3), .res_rem(a_res_rem), .res_len(a_res_len),
      .div_count(a_div_count), .err(a_err)
   );

   mod3_stream_checker #(.LEN_W(3), .CNT_W(2)) u_b (
      .clk(clk), .RESET(RESET), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof), .eof(eof),
      .res_valid(b_res_valid), .res_div3(b_res_div3), .res_rem(b_res_rem), .res_len(b_res_len),
      .div_count(b_div_count), .err(b_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_open = 1'b0; m_val = 0; m_len = 0; n_div = 0;
      exp_valid = 1'b0; exp_err = 1'b0; exp_div = 1'b0; exp_rem = 2'd0;
      exp_len_a = 6'd0; exp_len_b = 3'd0; exp_cnt_a = 8'd0; exp_cnt_b = 2'd0;
   endtask

   // drive one cycle, advance the model, leave time at posedge+1
   task automatic step(input logic v, input logic b, input logic s, input logic e);
      logic accepted;
      bit_valid = v; bit_in = b; sof = s; eof = e;
      @(posedge clk);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (v) begin
         accepted = s || m_open;
         exp_err  = s ? m_open : !m_open;
         if (s) begin
            m_val = b; m_len = 1;
         end else if (m_open) begin
            m_val = m_val * 2 + b; m_len = m_len + 1;
         end
         m_open = accepted;
         if (accepted && e) begin
            exp_valid = 1'b1;
            exp_rem   = 2'(m_val % 3);
            exp_div   = (m_val % 3 == 0);
            exp_len_a = 6'((m_len > 63) ? 63 : m_len);
            exp_len_b = 3'((m_len > 7) ? 7 : m_len);
            if (exp_div) n_div = n_div + 1;
            exp_cnt_a = 8'((n_div > 255) ? 255 : n_div);
            exp_cnt_b = 2'((n_div > 3) ? 3 : n_div);
            m_open = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      bit_valid = 1'($urandom); bit_in = 1'($urandom); sof = 1'($urandom); eof = 1'($urandom);
      RESET = 1'b1;
      model_reset();
      #1;
      n_checks++; if ({a_res_valid, a_res_div3, a_res_rem, a_res_len, a_div_count, a_err} !== 19'd0)
         $display("FAIL rst_a: got %h want 0", {a_res_valid, a_res_div3, a_res_rem, a_res_len, a_div_count, a_err}); else n_pass++;
      n_checks++; if ({b_res_valid, b_res_div3, b_res_rem, b_res_len, b_div_count, b_err} !== 10'd0)
         $display("FAIL rst_b: got %h want 0", {b_res_valid, b_res_div3, b_res_rem, b_res_len, b_div_count, b_err}); else n_pass++;
      #2 RESET = 1'b0;
      bit_valid = 1'b0;
   endtask

   task automatic test_frame6();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (a_res_valid !== 1'b0) $display("FAIL f6_early: got %0d want 0", a_res_valid); else n_pass++;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++; if ({a_res_valid, a_res_div3, a_res_rem} !== 4'b1100)
         $display("FAIL f6_res: got %b want 1100", {a_res_valid, a_res_div3, a_res_rem}); else n_pass++;
      n_checks++; if (a_res_len !== 6'd3) $display("FAIL f6_len: got %0d want 3", a_res_len); else n_pass++;
      n_checks++; if (a_div_count !== 8'd1) $display("FAIL f6_cnt: got %0d want 1", a_div_count); else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if ({a_res_valid, a_res_len} !== {1'b0, 6'd3})
         $display("FAIL f6_hold: got valid=%0d len=%0d want 0,3", a_res_valid, a_res_len); else n_pass++;
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++; if ({a_res_valid, a_res_div3, a_res_rem, a_res_len} !== {1'b1, 1'b0, 2'd2, 6'd4})
         $display("FAIL b2b_first: got v=%0d d=%0d r=%0d l=%0d want 1,0,2,4", a_res_valid, a_res_div3, a_res_rem, a_res_len); else n_pass++;
      n_checks++; if (a_div_count !== 8'd1) $display("FAIL b2b_cnt1: got %0d want 1", a_div_count); else n_pass++;
      step(1'b1, 1'b0, 1'b1, 1'b1);
      n_checks++; if ({a_res_valid, a_res_div3, a_res_rem, a_res_len} !== {1'b1, 1'b1, 2'd0, 6'd1})
         $display("FAIL b2b_second: got v=%0d d=%0d r=%0d l=%0d want 1,1,0,1", a_res_valid, a_res_div3, a_res_rem, a_res_len); else n_pass++;
      n_checks++; if (a_div_count !== 8'd2) $display("FAIL b2b_cnt2: got %0d want 2", a_div_count); else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_errors();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if ({a_err, a_res_valid} !== 2'b10) $display("FAIL err_nosof: got %b want 10", {a_err, a_res_valid}); else n_pass++;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++; if ({a_err, a_res_valid} !== 2'b10) $display("FAIL err_eof: got %b want 10", {a_err, a_res_valid}); else n_pass++;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++; if (a_err !== 1'b0) $display("FAIL err_clear: got %0d want 0", a_err); else n_pass++;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++; if ({a_err, a_res_valid} !== 2'b10) $display("FAIL err_resof: got %b want 10", {a_err, a_res_valid}); else n_pass++;
      step(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++; if ({a_err, a_res_valid, a_res_rem, a_res_len} !== {2'b01, 2'd0, 6'd2})
         $display("FAIL err_restart: got e=%0d v=%0d r=%0d l=%0d want 0,1,0,2", a_err, a_res_valid, a_res_rem, a_res_len); else n_pass++;
      n_checks++; if (a_div_count !== exp_cnt_a) $display("FAIL err_cnt: got %0d want %0d", a_div_count, exp_cnt_a); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      bit_valid = 1'($urandom); bit_in = 1'($urandom); sof = 1'($urandom); eof = 1'($urandom);
      RESET = 1'b1;
      model_reset();
      #1;
      n_checks++; if ({a_res_valid, a_res_len, a_div_count, a_err} !== 16'd0)
         $display("FAIL rmid_async: got %h want 0", {a_res_valid, a_res_len, a_div_count, a_err}); else n_pass++;
      #1 RESET = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if ({a_res_valid, a_err} !== 2'b00) $display("FAIL rmid_quiet: got %b want 00", {a_res_valid, a_err}); else n_pass++;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++; if ({a_res_valid, a_res_div3, a_res_len, a_div_count} !== {2'b11, 6'd4, 8'd1})
         $display("FAIL rmid_f9: got v=%0d d=%0d l=%0d c=%0d want 1,1,4,1", a_res_valid, a_res_div3, a_res_len, a_div_count); else n_pass++;
   endtask

   task automatic test_saturation();
      logic [1:0] want_b [5];
      want_b[0] = 2'd1; want_b[1] = 2'd2; want_b[2] = 2'd3; want_b[3] = 2'd3; want_b[4] = 2'd3;
      #2 RESET = 1'b1;
      model_reset();
      #2 RESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1);
         n_checks++; if (b_div_count !== want_b[i]) $display("FAIL sat_cnt%0d: got %0d want %0d", i, b_div_count, want_b[i]); else n_pass++;
         n_checks++; if (a_div_count !== 8'(i + 1)) $display("FAIL sat_cnta%0d: got %0d want %0d", i, a_div_count, i + 1); else n_pass++;
      end
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, (i == 0), (i == 9));
      n_checks++; if ({b_res_valid, b_res_len, b_res_rem, b_res_div3} !== {1'b1, 3'd7, 2'd0, 1'b1})
         $display("FAIL sat_len: got v=%0d l=%0d r=%0d want 1,7,0", b_res_valid, b_res_len, b_res_rem); else n_pass++;
      n_checks++; if (a_res_len !== 6'd10) $display("FAIL sat_len_a: got %0d want 10", a_res_len); else n_pass++;
   endtask

   task automatic test_random();
      logic v, b, s, e;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         b = 1'($urandom);
         s = m_open ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) != 0);
         e = ($urandom_range(0, 4) == 0) || (m_len >= 20);
         step(v, b, s, e);
         n_checks++;
         if ({a_res_valid, a_err, a_div_count, b_res_valid, b_err, b_div_count} !==
             {exp_valid, exp_err, exp_cnt_a, exp_valid, exp_err, exp_cnt_b})
            $display("FAIL rnd_strobe%0d: got %h want %h", i,
                     {a_res_valid, a_err, a_div_count, b_res_valid, b_err, b_div_count},
                     {exp_valid, exp_err, exp_cnt_a, exp_valid, exp_err, exp_cnt_b});
         else n_pass++;
         n_checks++;
         if ({a_res_rem, a_res_div3, a_res_len, b_res_rem, b_res_div3, b_res_len} !==
             {exp_rem, exp_div, exp_len_a, exp_rem, exp_div, exp_len_b})
            $display("FAIL rnd_fields%0d: got %h want %h", i,
                     {a_res_rem, a_res_div3, a_res_len, b_res_rem, b_res_div3, b_res_len},
                     {exp_rem, exp_div, exp_len_a, exp_rem, exp_div, exp_len_b});
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_frame6();
      test_back_to_back();
      test_errors();
      test_reset_mid_frame();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
